// File: rtl/bus_trace.sv
// 6502 address-bus tracer: captures addr_bus on each mpu_clk rise into a FIFO
// and drains entries as high/low byte pairs. Define BUS_TRACE_SYNC_EN to add input synchronisers.
module bus_trace #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mpu_clk,
    input  logic [15:0]           addr_bus,
    input  logic                  trace_en,
    input  logic                  tx_busy,
    output logic [7:0]            tx_data,
    output logic                  new_tx_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

    typedef enum logic [2:0] {
        IDLE,
        SEND_HI,
        GAP_HI,
        SEND_LO,
        GAP_LO
    } state_t;

    logic        mc;
    logic [15:0] ad;

`ifdef BUS_TRACE_SYNC_EN
    logic [1:0]  mc_sync;
    logic [15:0] ad_s1;
    logic [15:0] ad_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            mc_sync <= 2'b00;
            ad_s1   <= 16'h0000;
            ad_s2   <= 16'h0000;
        end else begin
            mc_sync <= {mc_sync[0], mpu_clk};
            ad_s1   <= addr_bus;
            ad_s2   <= ad_s1;
        end
    end

    assign mc = mc_sync[1];
    assign ad = ad_s2;
`else
    assign mc = mpu_clk;
    assign ad = addr_bus;
`endif

    state_t                state;
    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr;
    logic [DEPTH_LOG2-1:0] rptr;
    logic [15:0]           hold;
    logic [7:0]            last;
    logic                  mc_q;
    logic                  capture;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  send;
    logic [7:0]            byte_out;

    assign capture  = mc && !mc_q && trace_en;
    assign full     = (level == FULL);
    assign pop      = (state == IDLE) && (level != '0);
    // a full FIFO still accepts a capture when the drain pops in the same cycle
    assign push     = capture && (!full || pop);
    assign send     = ((state == SEND_HI) || (state == SEND_LO)) && !tx_busy;
    assign byte_out = (state == SEND_HI) ? hold[15:8] : hold[7:0];

    assign new_tx_data = send;
    assign tx_data     = send ? byte_out : last;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= ad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mc_q     <= 1'b1;
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            overflow <= 1'b0;
            hold     <= 16'h0000;
            last     <= 8'h00;
            state    <= IDLE;
        end else begin
            mc_q <= mc;
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            if (push && !pop) begin
                level <= level + LVL_ONE;
            end else if (pop && !push) begin
                level <= level - LVL_ONE;
            end
            if (!trace_en) begin
                overflow <= 1'b0;
            end else if (capture && full && !pop) begin
                overflow <= 1'b1;
            end
            if (send) begin
                last <= byte_out;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        hold  <= mem[rptr];
                        state <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (!tx_busy) begin
                        state <= GAP_HI;
                    end
                end
                GAP_HI: begin
                    state <= SEND_LO;
                end
                SEND_LO: begin
                    if (!tx_busy) begin
                        state <= GAP_LO;
                    end
                end
                GAP_LO: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
